// File: rtl/sysid_pkg.sv
// sysid_pkg: register map, CTRL/CAPS bit positions and CAPS builder.
// SYSID_IRQ_EN selects whether the compare interrupt is present.
package sysid_pkg;

  localparam int unsigned REG_ID   = 0;
  localparam int unsigned REG_TS   = 1;
  localparam int unsigned REG_CAPS = 2;
  localparam int unsigned REG_CTRL = 3;
  localparam int unsigned REG_UPLO = 4;
  localparam int unsigned REG_UPHI = 5;
  localparam int unsigned REG_ICMP = 6;
  localparam int unsigned REG_ISTS = 7;
  localparam int unsigned REG_SCR  = 8;

  localparam int unsigned CTRL_RUN = 0;
  localparam int unsigned CTRL_CLR = 1;
  localparam int unsigned CTRL_IEN = 2;
  localparam int unsigned CTRL_OVF = 8;

  localparam int unsigned CAPS_IRQ = 16;

`ifdef SYSID_IRQ_EN
  localparam logic IRQ_PRESENT = 1'b1;
`else
  localparam logic IRQ_PRESENT = 1'b0;
`endif

  function automatic logic [31:0] caps_word(
    input int unsigned nscr,
    input int unsigned uw,
    input logic        irq
  );
    logic [31:0] c;
    c           = '0;
    c[3:0]      = 4'(nscr);
    c[11:4]     = 8'(uw);
    c[CAPS_IRQ] = irq;
    return c;
  endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// sysid_uptime_ctr: prescaled uptime counter with overflow flag,
// high-word snapshot for atomic 64-bit reads and compare-match pulse.
module sysid_uptime_ctr #(
  parameter int unsigned UPTIME_W = 48,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_run,
  input  logic        i_clear,
  input  logic        i_snap,
  input  logic [31:0] i_cmp,
  output logic [31:0] o_lo,
  output logic [31:0] o_snap,
  output logic        o_ovf,
  output logic        o_hit
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW = UPTIME_W - 32;

  logic [PW-1:0]       r_pre;
  logic [UPTIME_W-1:0] r_count;
  logic [SW-1:0]       r_snap;
  logic                r_ovf;
  logic                w_tick;
  logic [UPTIME_W-1:0] w_next;

  assign w_tick = i_run && (r_pre == PW'(PRESCALE - 1));
  assign w_next = r_count + UPTIME_W'(1);
  assign o_hit  = w_tick && !i_clear && (w_next[31:0] == i_cmp);
  assign o_lo   = r_count[31:0];
  assign o_snap = 32'(r_snap);
  assign o_ovf  = r_ovf;

  // Prescale, count, latch snapshot; clear overrides everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pre   <= '0;
      r_count <= '0;
      r_snap  <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_pre   <= '0;
      r_count <= '0;
      r_snap  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (i_snap)
        r_snap <= r_count[UPTIME_W-1:32];
      if (w_tick) begin
        r_pre   <= '0;
        r_count <= w_next;
        if (&r_count)
          r_ovf <= 1'b1;
      end else if (i_run) begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

endmodule

// File: rtl/sysid_regs.sv
// sysid_regs: Avalon-MM system-ID / uptime / scratch register slave.
// SYSID_IRQ_EN adds IRQ_CMP, IRQ_STATUS and the irq output.
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h0,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned UPTIME_W    = 48,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              irq
);

  localparam logic [31:0] C_CAPS =
    caps_word(NUM_SCRATCH, UPTIME_W, IRQ_PRESENT);

  logic [31:0] r_scr [NUM_SCRATCH];
  logic        r_run;
  logic [31:0] r_rdata;
  logic        r_rdv;

  logic [31:0] w_addr32;
  logic        w_wr_ctrl;
  logic        w_clear;
  logic        w_snap;
  logic [31:0] w_lo;
  logic [31:0] w_snapv;
  logic        w_ovf;
  logic        w_hit;
  logic        w_ien;
  logic [31:0] w_cmp;
  logic        w_sts;
  logic [31:0] w_ctrl;
  logic [31:0] w_rdata;

  assign w_addr32  = 32'(address);
  assign w_wr_ctrl = write && (w_addr32 == REG_CTRL);
  assign w_clear   = w_wr_ctrl && writedata[CTRL_CLR];
  assign w_snap    = read && (w_addr32 == REG_UPLO);

  sysid_uptime_ctr #(
    .UPTIME_W (UPTIME_W),
    .PRESCALE (PRESCALE)
  ) u_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_run   (r_run),
    .i_clear (w_clear),
    .i_snap  (w_snap),
    .i_cmp   (w_cmp),
    .o_lo    (w_lo),
    .o_snap  (w_snapv),
    .o_ovf   (w_ovf),
    .o_hit   (w_hit)
  );

  // CTRL run bit; clear is a pulse and is not stored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_run <= 1'b0;
    else if (w_wr_ctrl)
      r_run <= writedata[CTRL_RUN];
  end

`ifdef SYSID_IRQ_EN
  logic        r_ien;
  logic [31:0] r_cmp;
  logic        r_sts;
  logic        r_irq;

  // irq_en, byte-lane compare value, sticky W1C status and registered irq.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ien <= 1'b0;
      r_cmp <= '0;
      r_sts <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr_ctrl)
        r_ien <= writedata[CTRL_IEN];
      if (write && (w_addr32 == REG_ICMP))
        for (int i = 0; i < 4; i++)
          if (byteenable[i])
            r_cmp[8*i +: 8] <= writedata[8*i +: 8];
      if (w_hit)
        r_sts <= 1'b1;
      else if (write && (w_addr32 == REG_ISTS) && writedata[0])
        r_sts <= 1'b0;
      r_irq <= r_sts & r_ien;
    end
  end

  assign w_ien = r_ien;
  assign w_cmp = r_cmp;
  assign w_sts = r_sts;
  assign irq   = r_irq;
`else
  logic w_unused;

  assign w_ien    = 1'b0;
  assign w_cmp    = '0;
  assign w_sts    = 1'b0;
  assign irq      = 1'b0;
  assign w_unused = w_hit;
`endif

  // Scratch registers with per-byte write lanes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SCRATCH; s++)
        r_scr[s] <= '0;
    end else if (write) begin
      for (int s = 0; s < NUM_SCRATCH; s++)
        if (w_addr32 == REG_SCR + 32'(s))
          for (int i = 0; i < 4; i++)
            if (byteenable[i])
              r_scr[s][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

  // Read mux over current (pre-write) register values.
  always_comb begin
    w_ctrl           = '0;
    w_ctrl[CTRL_RUN] = r_run;
    w_ctrl[CTRL_IEN] = w_ien;
    w_ctrl[CTRL_OVF] = w_ovf;
    w_rdata          = '0;
    case (w_addr32)
      REG_ID:   w_rdata = SYSTEM_ID;
      REG_TS:   w_rdata = TIMESTAMP;
      REG_CAPS: w_rdata = C_CAPS;
      REG_CTRL: w_rdata = w_ctrl;
      REG_UPLO: w_rdata = w_lo;
      REG_UPHI: w_rdata = w_snapv;
      REG_ICMP: w_rdata = w_cmp;
      REG_ISTS: w_rdata = {31'b0, w_sts};
      default: begin
        for (int s = 0; s < NUM_SCRATCH; s++)
          if (w_addr32 == REG_SCR + 32'(s))
            w_rdata = r_scr[s];
      end
    endcase
  end

  // One-cycle read response; data forced to 0 when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdv   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_rdv   <= read;
      r_rdata <= read ? w_rdata : '0;
    end
  end

  assign readdata      = r_rdata;
  assign readdatavalid = r_rdv;

endmodule

// File: tb/tb_sysid_regs.sv
// tb_sysid_regs: scoreboard bench for sysid_regs, two instances
// (48-bit/prescale 4 and 33-bit/prescale 1).
`timescale 1ns/1ps
module tb_sysid_regs;

  localparam logic [31:0] SID = 32'hCAFE_0001;
  localparam logic [31:0] TS  = 32'h6500_1234;
`ifdef SYSID_IRQ_EN
  localparam logic [31:0] CAPS0 = 32'h0001_0304;
  localparam logic [31:0] CAPS1 = 32'h0001_0212;
`else
  localparam logic [31:0] CAPS0 = 32'h0000_0304;
  localparam logic [31:0] CAPS1 = 32'h0000_0212;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address [2];
  logic [1:0]  read;
  logic [1:0]  write;
  logic [3:0]  be [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  rdv;
  logic [1:0]  irq;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  always #5 clock = ~clock;

  sysid_regs #(
    .SYSTEM_ID (SID),
    .TIMESTAMP (TS),
    .PRESCALE  (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address[0]),
    .read          (read[0]),
    .write         (write[0]),
    .byteenable    (be[0]),
    .writedata     (wdata[0]),
    .readdata      (rdata[0]),
    .readdatavalid (rdv[0]),
    .irq           (irq[0])
  );

  sysid_regs #(
    .NUM_SCRATCH (2),
    .UPTIME_W    (33),
    .PRESCALE    (1)
  ) dut33 (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address[1]),
    .read          (read[1]),
    .write         (write[1]),
    .byteenable    (be[1]),
    .writedata     (wdata[1]),
    .readdata      (rdata[1]),
    .readdatavalid (rdv[1]),
    .irq           (irq[1])
  );

  // Response monitors: a read sampled on an edge must answer right after it.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(posedge clock) begin : mon
      logic        ev;
      logic [31:0] e;
      ev = read[g] && reset_n;
      #1;
      n_chk++;
      if (rdv[g] !== ev) begin
        n_fail++;
        $display("FAIL rdv bus%0d t=%0t got %b want %b", g, $time, rdv[g], ev);
      end else if (ev) begin
        if ((g == 0 ? q0.size() : q1.size()) == 0) begin
          n_fail++;
          $display("FAIL sb_empty bus%0d t=%0t got %h", g, $time, rdata[g]);
        end else begin
          e = (g == 0) ? q0.pop_front() : q1.pop_front();
          if (rdata[g] !== e) begin
            n_fail++;
            $display("FAIL rdata bus%0d t=%0t got %h want %h",
                     g, $time, rdata[g], e);
          end
        end
      end else if (rdata[g] !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_rdata bus%0d t=%0t got %h want 0", g, $time, rdata[g]);
      end
    end
  end

  task automatic wr(input int b, input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] m = 4'hF);
    address[b] = a;
    wdata[b]   = d;
    be[b]      = m;
    write[b]   = 1'b1;
    @(negedge clock);
    write[b]   = 1'b0;
  endtask

  task automatic rd(input int b, input logic [3:0] a, input logic [31:0] e);
    if (b == 0) q0.push_back(e);
    else        q1.push_back(e);
    address[b] = a;
    read[b]    = 1'b1;
    @(negedge clock);
    read[b]    = 1'b0;
  endtask

  // Counter runs on exactly n clock edges, then stops.
  task automatic run_edges(input int b, input int n);
    wr(b, 4'd3, 32'h1);
    repeat (n - 1) @(negedge clock);
    wr(b, 4'd3, 32'h0);
  endtask

  task automatic test_reset;
    read = '0; write = '0;
    for (int b = 0; b < 2; b++) begin
      address[b] = '0; be[b] = '0; wdata[b] = '0;
    end
    repeat (3) @(negedge clock);
    n_chk++;
    if ({rdv, irq} !== 4'b0 || rdata[0] !== 0 || rdata[1] !== 0) begin
      n_fail++;
      $display("FAIL reset_out got rdv=%b irq=%b d0=%h d1=%h want 0",
               rdv, irq, rdata[0], rdata[1]);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_id;
    rd(0, 4'd0, SID);
    rd(0, 4'd1, TS);
    rd(0, 4'd2, CAPS0);
    rd(0, 4'd3, 32'h0);
    rd(0, 4'd4, 32'h0);
    rd(1, 4'd0, 32'h0);
    rd(1, 4'd2, CAPS1);
    wr(0, 4'd0, 32'hFFFF_FFFF);
    wr(0, 4'd2, 32'hFFFF_FFFF);
    rd(0, 4'd0, SID);
    rd(0, 4'd2, CAPS0);
  endtask

  task automatic test_uptime;
    run_edges(0, 40);
    rd(0, 4'd4, 32'd10);
    rd(0, 4'd5, 32'd0);
    rd(0, 4'd3, 32'h0);
    wr(0, 4'd3, 32'h2);
    rd(0, 4'd4, 32'd0);
    rd(0, 4'd3, 32'h0);
  endtask

  task automatic test_atomic;
    force dut.u_ctr.r_count = 48'h0000_FFFF_FFFF;
    @(negedge clock);
    release dut.u_ctr.r_count;
    rd(0, 4'd4, 32'hFFFF_FFFF);
    run_edges(0, 4);
    rd(0, 4'd5, 32'h0);
    rd(0, 4'd4, 32'h0);
    rd(0, 4'd5, 32'h1);
    wr(0, 4'd3, 32'h2);
    rd(0, 4'd5, 32'h0);
  endtask

  task automatic test_overflow;
    force dut33.u_ctr.r_count = 33'h1_FFFF_FFFF;
    @(negedge clock);
    release dut33.u_ctr.r_count;
    rd(1, 4'd3, 32'h0);
    run_edges(1, 1);
    rd(1, 4'd4, 32'h0);
    rd(1, 4'd5, 32'h0);
    rd(1, 4'd3, 32'h100);
    wr(1, 4'd3, 32'h2);
    rd(1, 4'd3, 32'h0);
  endtask

  task automatic test_scratch;
    wr(0, 4'd8, 32'hAABB_CCDD, 4'b0101);
    rd(0, 4'd8, 32'h00BB_00DD);
    wr(0, 4'd8, 32'h1122_3344, 4'b1010);
    rd(0, 4'd8, 32'h11BB_33DD);
    wr(0, 4'd11, 32'hDEAD_BEEF);
    rd(0, 4'd11, 32'hDEAD_BEEF);
    wr(0, 4'd12, 32'h5555_5555);
    rd(0, 4'd12, 32'h0);
    wr(0, 4'd15, 32'h1234_5678);
    rd(0, 4'd15, 32'h0);
    wr(1, 4'd9, 32'hCAFE_F00D);
    wr(1, 4'd10, 32'h7777_7777);
    rd(1, 4'd9, 32'hCAFE_F00D);
    rd(1, 4'd10, 32'h0);
  endtask

  task automatic test_back_to_back;
    wr(0, 4'd9, 32'h1111_1111);
    q0.push_back(32'h1111_1111);
    address[0] = 4'd9;
    wdata[0]   = 32'h2222_2222;
    be[0]      = 4'hF;
    read[0]    = 1'b1;
    write[0]   = 1'b1;
    @(negedge clock);
    write[0]   = 1'b0;
    read[0]    = 1'b0;
    rd(0, 4'd9, 32'h2222_2222);
    rd(0, 4'd8, 32'h11BB_33DD);
    rd(0, 4'd9, 32'h2222_2222);
  endtask

  task automatic test_irq;
    int rise;
    int hi;
    rise = -1;
    hi   = 0;
    wr(0, 4'd3, 32'h2);
    wr(0, 4'd6, 32'd5);
    wr(0, 4'd3, 32'h5);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (irq[0] === 1'b1) hi++;
      if (irq[0] === 1'b1 && rise < 0) rise = i;
    end
`ifdef SYSID_IRQ_EN
    n_chk++;
    if (rise != 21) begin
      n_fail++;
      $display("FAIL irq_rise got edge %0d want 21", rise);
    end
    rd(0, 4'd6, 32'd5);
    rd(0, 4'd7, 32'h1);
    rd(0, 4'd3, 32'h5);
    wr(0, 4'd7, 32'h1);
    n_chk++;
    if (irq[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_w1c_hold got %b want 1", irq[0]);
    end
    @(negedge clock);
    n_chk++;
    if (irq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_w1c_drop got %b want 0", irq[0]);
    end
    rd(0, 4'd7, 32'h0);
`else
    n_chk++;
    if (hi != 0) begin
      n_fail++;
      $display("FAIL irq_absent got %0d high cycles want 0", hi);
    end
    rd(0, 4'd6, 32'h0);
    rd(0, 4'd7, 32'h0);
    rd(0, 4'd3, 32'h1);
`endif
    wr(0, 4'd3, 32'h2);
    n_chk++;
    if (irq[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_dut33 got %b want 0", irq[1]);
    end
  endtask

  initial begin
    test_reset;
    test_id;
    test_uptime;
    test_atomic;
    test_overflow;
    test_scratch;
    test_back_to_back;
    test_irq;
    repeat (3) @(negedge clock);
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
